// File: rtl/lsu_data_ram_if.sv
// Request/response bundle between the load/store unit and lsu_data_ram.
// Requests are accepted on req_valid && req_ready. Responses are never back-pressured.
interface lsu_data_ram_if #(
    parameter int ADDR_W = 13
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_data_ram.sv
// Byte-addressed single-port data RAM for RISC-V loads/stores.
// Optional zero-clear after reset. In-order responses after LATENCY (1 or 2) cycles.
module lsu_data_ram #(
    parameter int DEPTH          = 2048,
    parameter int LATENCY        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    lsu_data_ram_if.slave bus,
    output logic          init_done
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int ADDR_W = IDX_W + 2;

    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_q, clr_d;
    logic             clear_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // Handshake and init_done are also gated by rst so that they read 0 while rst is held.
    always_comb begin
        state_d       = state_q;
        clr_d         = clr_q;
        clear_we      = 1'b0;
        bus.req_ready = 1'b0;
        init_done     = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                clr_d   = '0;
                state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            end
            ST_CLEAR: begin
                clear_we = !rst;
                clr_d    = clr_q + IDX_W'(1);
                if (clr_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                bus.req_ready = !rst;
                init_done     = !rst;
            end
            default: state_d = ST_RESET;
        endcase
    end

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             accept, legal, st_acc, ld_acc;
    logic [3:0]       be;
    logic [31:0]      wdata_al;

    assign idx    = bus.req_addr[ADDR_W-1:2];
    assign lane   = bus.req_addr[1:0];
    assign accept = bus.req_valid && bus.req_ready;
    assign st_acc = accept && bus.req_we && legal;
    assign ld_acc = accept && !bus.req_we && legal;

    always_comb begin
        legal = 1'b0;
        case (bus.req_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = !bus.req_addr[0];
            3'b010:  legal = (lane == 2'b00);
            3'b100:  legal = !bus.req_we;
            3'b101:  legal = !bus.req_we && !bus.req_addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        be       = 4'b1111;
        wdata_al = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                be       = 4'b0001 << lane;
                wdata_al = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clr_q] <= '0;
        end else if (st_acc) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= wdata_al[8*k +: 8];
            end
        end
        if (ld_acc) rd_q <= mem[idx];
    end

    logic       v1_q, err1_q, load1_q;
    logic [2:0] f3_1_q;
    logic [1:0] lane1_q;

    always_ff @(posedge clk) begin
        if (rst) v1_q <= 1'b0;
        else     v1_q <= accept;
        if (accept) begin
            err1_q  <= !legal;
            load1_q <= !bus.req_we;
            f3_1_q  <= bus.req_funct3;
            lane1_q <= lane;
        end
    end

    logic [31:0] shifted, ext, data1;
    logic        err1;

    always_comb begin
        shifted = rd_q >> {lane1_q, 3'b000};
        case (f3_1_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
        data1 = (v1_q && load1_q && !err1_q) ? ext : '0;
        err1  = v1_q && err1_q;
    end

    logic        v_out, err_out;
    logic [31:0] data_out;

    if (LATENCY == 2) begin : g_lat2
        logic        v2_q, err2_q;
        logic [31:0] data2_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                v2_q    <= 1'b0;
                err2_q  <= 1'b0;
                data2_q <= '0;
            end else begin
                v2_q    <= v1_q;
                err2_q  <= err1;
                data2_q <= data1;
            end
        end
        assign v_out    = v2_q;
        assign err_out  = err2_q;
        assign data_out = data2_q;
    end else begin : g_lat1
        assign v_out    = v1_q;
        assign err_out  = err1;
        assign data_out = data1;
    end

    assign bus.rsp_valid = v_out && !rst;
    assign bus.rsp_err   = err_out && !rst;
    assign bus.rsp_rdata = rst ? '0 : data_out;
endmodule

// File: tb/tb_lsu_data_ram.sv
// Scoreboard bench for lsu_data_ram. u_a has DEPTH=16 and LATENCY=1. u_b has DEPTH=16 and LATENCY=2.
// Both instances clear their arrays on reset.
module tb_lsu_data_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, done_a, done_b;

    lsu_data_ram_if #(.ADDR_W(6)) ifa ();
    lsu_data_ram_if #(.ADDR_W(6)) ifb ();

    lsu_data_ram #(.DEPTH(16), .LATENCY(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst(rst_a), .bus(ifa), .init_done(done_a)
    );
    lsu_data_ram #(.DEPTH(16), .LATENCY(2), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst(rst_b), .bus(ifb), .init_done(done_b)
    );

    typedef struct {
        string       nm;
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // One clock step: sample both DUTs at the falling edge and pop any response that is due.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (q_a.size() > 0 && q_a[0].due == cyc) begin
            e = q_a.pop_front();
            n_cmp++;
            if (ifa.rsp_valid !== 1'b1 || ifa.rsp_rdata !== e.data || ifa.rsp_err !== e.err) begin
                n_bad++;
                $display("FAIL a.%s: got v=%b d=%h e=%b, want v=1 d=%h e=%b",
                         e.nm, ifa.rsp_valid, ifa.rsp_rdata, ifa.rsp_err, e.data, e.err);
            end
        end else if (ifa.rsp_valid !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a.unexpected_rsp: got v=%b d=%h at cyc %0d, want v=0", ifa.rsp_valid, ifa.rsp_rdata, cyc);
        end
        if (q_b.size() > 0 && q_b[0].due == cyc) begin
            e = q_b.pop_front();
            n_cmp++;
            if (ifb.rsp_valid !== 1'b1 || ifb.rsp_rdata !== e.data || ifb.rsp_err !== e.err) begin
                n_bad++;
                $display("FAIL b.%s: got v=%b d=%h e=%b, want v=1 d=%h e=%b",
                         e.nm, ifb.rsp_valid, ifb.rsp_rdata, ifb.rsp_err, e.data, e.err);
            end
        end else if (ifb.rsp_valid !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b.unexpected_rsp: got v=%b d=%h at cyc %0d, want v=0", ifb.rsp_valid, ifb.rsp_rdata, cyc);
        end
    endtask

    task automatic req_a(input string nm, input logic we, input logic [2:0] f3, input logic [5:0] ad,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        n_cmp++;
        if (ifa.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL a.ready_%s: got %b, want 1", nm, ifa.req_ready);
        end
        ifa.req_valid = 1'b1; ifa.req_we = we; ifa.req_funct3 = f3; ifa.req_addr = ad; ifa.req_wdata = wd;
        q_a.push_back('{nm, cyc + 1, ed, ee});
        tick();
        ifa.req_valid = 1'b0;
    endtask

    task automatic req_b(input string nm, input logic we, input logic [2:0] f3, input logic [5:0] ad,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        n_cmp++;
        if (ifb.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b.ready_%s: got %b, want 1", nm, ifb.req_ready);
        end
        ifb.req_valid = 1'b1; ifb.req_we = we; ifb.req_funct3 = f3; ifb.req_addr = ad; ifb.req_wdata = wd;
        q_b.push_back('{nm, cyc + 2, ed, ee});
        tick();
        ifb.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) tick();
        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q_a.size(), q_b.size());
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.req_valid = 1'b0; ifb.req_valid = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({ifa.req_ready, ifa.rsp_valid, ifa.rsp_err, done_a, ifb.req_ready, ifb.rsp_valid, ifb.rsp_err, done_b} !== 8'h00
            || ifa.rsp_rdata !== 32'h0 || ifb.rsp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got a=%b%b%b%b b=%b%b%b%b, want all 0",
                     ifa.req_ready, ifa.rsp_valid, ifa.rsp_err, done_a, ifb.req_ready, ifb.rsp_valid, ifb.rsp_err, done_b);
        end
    endtask

    task automatic test_clear();
        int  na = 0, nb = 0;
        bit  fa = 0, fb = 0, early = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        for (int i = 0; i < 40 && !(fa && fb); i++) begin
            tick();
            if (!fa) begin
                if (ifa.req_ready === 1'b1) fa = 1; else begin na++; if (done_a !== 1'b0) early = 1; end
            end
            if (!fb) begin
                if (ifb.req_ready === 1'b1) fb = 1; else begin nb++; if (done_b !== 1'b0) early = 1; end
            end
        end
        n_cmp++;
        if (na != 16 || nb != 16 || !fa || !fb) begin
            n_bad++;
            $display("FAIL clear_cycles: got a=%0d b=%0d, want 16", na, nb);
        end
        n_cmp++;
        if (done_a !== 1'b1 || done_b !== 1'b1 || early) begin
            n_bad++;
            $display("FAIL init_done: got a=%b b=%b early=%b, want 1 1 0", done_a, done_b, early);
        end
        req_a("lw_3c_cleared", 1'b0, 3'b010, 6'h3C, 32'h0, 32'h0, 1'b0);
        req_b("lw_3c_cleared", 1'b0, 3'b010, 6'h3C, 32'h0, 32'h0, 1'b0);
        drain();
    endtask

    task automatic test_extension();
        req_a("sw_8",   1'b1, 3'b010, 6'h08, 32'hDEADBEEF, 32'h0, 1'b0);
        req_a("lw_8",   1'b0, 3'b010, 6'h08, 32'h0, 32'hDEADBEEF, 1'b0);
        req_a("lb_9",   1'b0, 3'b000, 6'h09, 32'h0, 32'hFFFFFFBE, 1'b0);
        req_a("lbu_b",  1'b0, 3'b100, 6'h0B, 32'h0, 32'h000000DE, 1'b0);
        req_a("lh_a",   1'b0, 3'b001, 6'h0A, 32'h0, 32'hFFFFDEAD, 1'b0);
        req_a("lhu_8",  1'b0, 3'b101, 6'h08, 32'h0, 32'h0000BEEF, 1'b0);
        drain();
    endtask

    task automatic test_byte_half();
        req_a("sb_a",   1'b1, 3'b000, 6'h0A, 32'hFFFFFF12, 32'h0, 1'b0);
        req_a("sh_8",   1'b1, 3'b001, 6'h08, 32'hFFFF5678, 32'h0, 1'b0);
        req_a("lw_8_m", 1'b0, 3'b010, 6'h08, 32'h0, 32'hDE125678, 1'b0);
        drain();
    endtask

    task automatic test_errors();
        req_a("sw_4",      1'b1, 3'b010, 6'h04, 32'h13579BDF, 32'h0, 1'b0);
        req_a("sh_5_mis",  1'b1, 3'b001, 6'h05, 32'h0000AAAA, 32'h0, 1'b1);
        req_a("lw_6_mis",  1'b0, 3'b010, 6'h06, 32'h0, 32'h0, 1'b1);
        req_a("ld_f3_011", 1'b0, 3'b011, 6'h04, 32'h0, 32'h0, 1'b1);
        req_a("st_f3_100", 1'b1, 3'b100, 6'h04, 32'hFFFFFFFF, 32'h0, 1'b1);
        req_a("lw_4_kept", 1'b0, 3'b010, 6'h04, 32'h0, 32'h13579BDF, 1'b0);
        req_a("lb_4",      1'b0, 3'b000, 6'h04, 32'h0, 32'hFFFFFFDF, 1'b0);
        req_a("lbu_5",     1'b0, 3'b100, 6'h05, 32'h0, 32'h0000009B, 1'b0);
        drain();
    endtask

    task automatic test_boundary();
        req_a("sb_3f",  1'b1, 3'b000, 6'h3F, 32'h00000080, 32'h0, 1'b0);
        req_a("lb_3f",  1'b0, 3'b000, 6'h3F, 32'h0, 32'hFFFFFF80, 1'b0);
        req_a("lbu_3f", 1'b0, 3'b100, 6'h3F, 32'h0, 32'h00000080, 1'b0);
        req_a("lh_3e",  1'b0, 3'b001, 6'h3E, 32'h0, 32'hFFFF8000, 1'b0);
        req_a("lhu_3e", 1'b0, 3'b101, 6'h3E, 32'h0, 32'h00008000, 1'b0);
        req_a("lw_3c",  1'b0, 3'b010, 6'h3C, 32'h0, 32'h80000000, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'd1; vals[1] = 32'd6; vals[2] = 32'd100; vals[3] = 32'hA;
        for (int i = 0; i < 4; i++)
            req_b("sw_pre", 1'b1, 3'b010, 6'(4 * i), vals[i], 32'h0, 1'b0);
        for (int i = 0; i < 4; i++)
            req_b("lw_b2b", 1'b0, 3'b010, 6'(4 * i), 32'h0, vals[i], 1'b0);
        drain();
    endtask

    task automatic test_reset_mid_clear();
        int  n = 0;
        bit  f = 0;
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        repeat (8) tick();
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        for (int i = 0; i < 40 && !f; i++) begin
            tick();
            if (ifa.req_ready === 1'b1) f = 1; else n++;
        end
        n_cmp++;
        if (n != 16 || !f) begin
            n_bad++;
            $display("FAIL midclear_cycles: got %0d, want 16", n);
        end
        req_a("lw_8_clr",  1'b0, 3'b010, 6'h08, 32'h0, 32'h0, 1'b0);
        req_a("lw_3c_clr", 1'b0, 3'b010, 6'h3C, 32'h0, 32'h0, 1'b0);
        drain();
    endtask

    task automatic test_reset_inflight();
        bit f = 0;
        ifb.req_valid = 1'b1; ifb.req_we = 1'b0; ifb.req_funct3 = 3'b010; ifb.req_addr = 6'h00;
        tick();
        ifb.req_addr = 6'h04;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        ifb.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (ifb.rsp_valid !== 1'b0 || ifb.rsp_rdata !== 32'h0) begin
                n_bad++;
                $display("FAIL inflight_rst: got v=%b d=%h, want v=0 d=0", ifb.rsp_valid, ifb.rsp_rdata);
            end
        end
        rst_b = 1'b0;
        for (int i = 0; i < 40 && !f; i++) begin
            tick();
            if (ifb.req_ready === 1'b1) f = 1;
        end
        n_cmp++;
        if (!f) begin
            n_bad++;
            $display("FAIL inflight_ready: got 0, want 1 within 40 cycles");
        end
        req_b("lw_0_after", 1'b0, 3'b010, 6'h00, 32'h0, 32'h0, 1'b0);
        drain();
    endtask

    initial begin
        ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_funct3 = '0; ifa.req_addr = '0; ifa.req_wdata = '0;
        ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_funct3 = '0; ifb.req_addr = '0; ifb.req_wdata = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        test_reset();
        test_clear();
        test_extension();
        test_byte_half();
        test_errors();
        test_boundary();
        test_back_to_back();
        test_reset_mid_clear();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
